scroll_ctrl: RTL and testbench
==============================

SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 Parameter FRAME_MAX, default 3096: course length in pixels; frame_counter wraps modulo this value.
REQ-002 Parameter STEP_MIN, default 2: initial scroll step in pixels per frame.
REQ-003 Parameter STEP_MAX, default 6: maximum scroll step in pixels per frame.
REQ-004 Parameter RAMP_FRAMES, default 600: number of RUN frame ticks per step increment.
REQ-005 Clk  in  1  system clock (50 MHz); the only clock in the block.
REQ-006 Reset_n  in  1  reset, synchronous to Clk, active-low.
REQ-007 frame_clk  in  1  frame strobe (~60 Hz), synchronous to Clk, level signal.
REQ-008 start  in  1  start/restart request, level signal, sampled each Clk.
REQ-009 pause  in  1  pause request, level signal: high means paused.
REQ-010 hit  in  1  fatal collision from game logic.
REQ-011 coin_hit  in  3  per-coin collect request; bit i clears coin i.
REQ-012 frame_counter  out  12  current scroll offset into the terrain map.
REQ-013 step  out  3  current scroll step.
REQ-014 CoinStatus  out  3  per-coin visible flag (1 = visible).
REQ-015 playing  out  1  high when state is RUN.
REQ-016 lap_done  out  1  one-Clk pulse on each course wrap.
REQ-017 state  out  2  FSM state encoding: IDLE=0, RUN=1, PAUSE=2, OVER=3.

Function
REQ-018 Frame tick generation: tick = frame_clk high and frame_clk high-registered-previous low, registered, so the tick fires exactly one Clk after the sampled rising edge, one Clk wide.
REQ-019 FSM transitions:
- IDLE -> RUN on start.
- RUN -> OVER on hit.
- RUN -> PAUSE on pause when hit is low.
- PAUSE -> RUN on pause low.
- OVER -> IDLE on start.
- Every other case holds the current state.
REQ-020 In IDLE: frame_counter=0, step=STEP_MIN, ramp counter=0, CoinStatus=3'b111.
REQ-021 In RUN, on a tick: next = frame_counter + step, computed at 13 bits; if next >= FRAME_MAX, frame_counter = next - FRAME_MAX and lap_done pulses in that cycle; otherwise frame_counter = next.
REQ-022 frame_counter, step and the ramp counter change only on a tick while in RUN; they hold in PAUSE and OVER.
REQ-023 Ramp: each RUN tick increments the ramp counter. On the tick where the counter equals RAMP_FRAMES-1, the counter returns to 0 and step increments, saturating at STEP_MAX.
REQ-024 Coins: in RUN, any cycle, each coin_hit bit that is set clears the matching CoinStatus bit. coin_hit is ignored in IDLE, PAUSE and OVER.
REQ-025 Coin/wrap collision: on a wrap tick, CoinStatus is set to 3'b111, overriding any coin_hit in the same cycle.
REQ-026 Hit priority: hit in RUN coincident with a tick wins; state goes to OVER and frame_counter, step and CoinStatus are not updated in that cycle.
REQ-027 start coincident with hit while in RUN is ignored (hit wins).
REQ-028 start held continuously through OVER -> IDLE does not re-enter RUN until the IDLE cycle after; IDLE requires start sampled while in IDLE.
REQ-029 All outputs are registered; playing and state reflect the current state register.

Reset
REQ-030 Reset_n low at a Clk edge forces: state=IDLE, frame_counter=0, step=STEP_MIN, CoinStatus=3'b111, lap_done=0, playing=0, ramp counter=0, tick pipeline=0.
REQ-031 Reset asserted mid-RUN or mid-tick takes effect at the next Clk edge and overrides every other input.

Structure
REQ-032 A shared package game_pkg holds: the state enum (IDLE/RUN/PAUSE/OVER), FRAME_MAX, STEP_MIN, STEP_MAX, RAMP_FRAMES and COIN_NUM=3.
REQ-033 Sub-module frame_tick (edge detector, REQ-018) is instantiated once; the FSM, scroll, ramp and coin logic sit in scroll_ctrl.

Verification
REQ-034 Reset then start, 3 ticks -> state=RUN, frame_counter=6, step=2, CoinStatus=111.
REQ-035 frame_counter=3094, step=2, tick -> frame_counter=0 with a one-Clk lap_done; with step=4 from 3094 -> frame_counter=2.
REQ-036 RUN for 600 ticks -> step=3 after tick 600; after 2400 more ticks -> step saturates at 6.
REQ-037 coin_hit=010 in RUN -> CoinStatus=101 the next Clk; coin_hit=001 on a wrap tick -> CoinStatus=111.
REQ-038 pause high for 10 ticks -> frame_counter and step unchanged, state=PAUSE, playing=0; pause low -> RUN resumes from the same offset.
REQ-039 hit coincident with a tick at frame_counter=100 -> state=OVER, frame_counter=100; then start -> IDLE with frame_counter=0; Reset_n low mid-RUN -> all reset values next Clk.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared constants and types for the side-scroller control
//                path: FSM state encoding, course length, scroll-step limits,
//                ramp period and coin count.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Default course length in pixels; frame_counter wraps modulo this value.
    localparam int FRAME_MAX   = 3096;
    // Scroll step limits in pixels per frame.
    localparam int STEP_MIN    = 2;
    localparam int STEP_MAX    = 6;
    // RUN frame ticks between step increments.
    localparam int RAMP_FRAMES = 600;
    // Number of independently collectable coins.
    localparam int COIN_NUM    = 3;

    // Encoding is visible on the state output port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/frame_tick.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick
//  Description : Rising-edge detector for the frame strobe. Produces a single
//                Clk-wide registered tick one Clk after the rising edge of
//                frame_clk is sampled.
//  Revision    : 1.0  initial release
//
//  Ports
//    Clk        in   system clock
//    Reset_n    in   synchronous active-low reset
//    frame_clk  in   frame strobe level (synchronous to Clk)
//    tick       out  one-Clk pulse per frame_clk rising edge
// ============================================================================
module frame_tick (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic frame_clk_q, frame_clk_d;
    logic tick_q, tick_d;

    always_comb begin
        frame_clk_d = frame_clk;
        // High only on the first Clk where the strobe is seen high.
        tick_d      = frame_clk & ~frame_clk_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_clk_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk_d;
            tick_q      <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule : frame_tick
`default_nettype wire

// File: rtl/scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_ctrl
//  Description : Game flow FSM (IDLE/RUN/PAUSE/OVER) with terrain scroll
//                offset, speed ramp and per-coin visibility tracking.
//  Revision    : 1.0  initial release
//
//  Ports
//    Clk            in   system clock
//    Reset_n        in   synchronous active-low reset
//    frame_clk      in   frame strobe level
//    start          in   start / restart request
//    pause          in   pause request (high = paused)
//    hit            in   fatal collision
//    coin_hit[2:0]  in   per-coin collect request
//    frame_counter  out  scroll offset into the terrain map
//    step[2:0]      out  current scroll step
//    CoinStatus     out  per-coin visible flags
//    playing        out  high while in RUN
//    lap_done       out  one-Clk pulse on course wrap
//    state[1:0]     out  current FSM state
// ============================================================================
module scroll_ctrl #(
    parameter int FRAME_MAX   = game_pkg::FRAME_MAX,
    parameter int STEP_MIN    = game_pkg::STEP_MIN,
    parameter int STEP_MAX    = game_pkg::STEP_MAX,
    parameter int RAMP_FRAMES = game_pkg::RAMP_FRAMES
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        pause,
    input  logic        hit,
    input  logic [2:0]  coin_hit,
    output logic [11:0] frame_counter,
    output logic [2:0]  step,
    output logic [2:0]  CoinStatus,
    output logic        playing,
    output logic        lap_done,
    output logic [1:0]  state
);

    import game_pkg::*;

    localparam int c_ramp_w = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

    state_t                state_q, state_d;
    logic [11:0]           frame_counter_q, frame_counter_d;
    logic [2:0]            step_q, step_d;
    logic [c_ramp_w-1:0]   ramp_q, ramp_d;
    logic [COIN_NUM-1:0]   coin_q, coin_d;
    logic                  lap_done_q, lap_done_d;

    logic                  tick;
    logic [12:0]           sum;

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // One extra bit so the wrap comparison never overflows.
    assign sum = {1'b0, frame_counter_q} + {10'd0, step_q};

    always_comb begin
        state_d         = state_q;
        frame_counter_d = frame_counter_q;
        step_d          = step_q;
        ramp_d          = ramp_q;
        coin_d          = coin_q;
        lap_done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // IDLE continuously re-arms the course.
                frame_counter_d = '0;
                step_d          = 3'(STEP_MIN);
                ramp_d          = '0;
                coin_d          = '1;
                if (start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                // A collision freezes everything for this cycle, including
                // coins and any coincident tick or start.
                if (hit) begin
                    state_d = OVER;
                end else begin
                    if (pause) begin
                        state_d = PAUSE;
                    end
                    coin_d = coin_q & ~coin_hit;
                    if (tick) begin
                        if (sum >= 13'(FRAME_MAX)) begin
                            frame_counter_d = 12'(sum - 13'(FRAME_MAX));
                            lap_done_d      = 1'b1;
                            // A new lap restores every coin, even one being
                            // collected in this same cycle.
                            coin_d          = '1;
                        end else begin
                            frame_counter_d = sum[11:0];
                        end

                        if (ramp_q == c_ramp_w'(RAMP_FRAMES - 1)) begin
                            ramp_d = '0;
                            if (step_q < 3'(STEP_MAX)) begin
                                step_d = step_q + 3'd1;
                            end
                        end else begin
                            ramp_d = ramp_q + c_ramp_w'(1);
                        end
                    end
                end
            end

            PAUSE: begin
                if (!pause) begin
                    state_d = RUN;
                end
            end

            OVER: begin
                // Clear on the way out so IDLE shows the fresh course at once.
                if (start) begin
                    state_d         = IDLE;
                    frame_counter_d = '0;
                    step_d          = 3'(STEP_MIN);
                    ramp_d          = '0;
                    coin_d          = '1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q         <= IDLE;
            frame_counter_q <= '0;
            step_q          <= 3'(STEP_MIN);
            ramp_q          <= '0;
            coin_q          <= '1;
            lap_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_counter_q <= frame_counter_d;
            step_q          <= step_d;
            ramp_q          <= ramp_d;
            coin_q          <= coin_d;
            lap_done_q      <= lap_done_d;
        end
    end

    assign frame_counter = frame_counter_q;
    assign step          = step_q;
    assign CoinStatus    = coin_q;
    assign playing       = (state_q == RUN);
    assign lap_done      = lap_done_q;
    assign state         = state_q;

endmodule : scroll_ctrl
`default_nettype wire

// File: tb/tb_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scroll_ctrl
//  Description : Self-checking bench for scroll_ctrl. A reference model built
//                from total-tick arithmetic tracks the expected outputs and is
//                compared every cycle; directed sequences pin the model with
//                hand-computed values, then randomized stimulus follows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scroll_ctrl;

    localparam int FM   = 3096;
    localparam int SMIN = 2;
    localparam int SMAX = 6;
    localparam int RAMP = 600;

    logic        Clk;
    logic        Reset_n;
    logic        frame_clk;
    logic        start;
    logic        pause;
    logic        hit;
    logic [2:0]  coin_hit;
    logic [11:0] frame_counter;
    logic [2:0]  step;
    logic [2:0]  CoinStatus;
    logic        playing;
    logic        lap_done;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    scroll_ctrl dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .start         (start),
        .pause         (pause),
        .hit           (hit),
        .coin_hit      (coin_hit),
        .frame_counter (frame_counter),
        .step          (step),
        .CoinStatus    (CoinStatus),
        .playing       (playing),
        .lap_done      (lap_done),
        .state         (state)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: step and ramp derive from the count of RUN ticks
    // since the course was armed; the offset advances modulo FM.
    // ------------------------------------------------------------------
    int m_state, m_fc, m_step, m_coin, m_lap, m_runticks;
    bit m_prev, m_tick, m_valid = 0;

    task automatic m_arm();
        m_fc = 0; m_step = SMIN; m_coin = 7; m_runticks = 0;
    endtask

    always @(posedge Clk) begin
        bit tick_now;
        int sum;
        tick_now = m_tick;
        if (!Reset_n) begin
            m_valid = 1; m_state = 0; m_lap = 0; m_prev = 0; m_tick = 0;
            m_arm();
        end else begin
            m_tick = frame_clk && !m_prev;
            m_prev = frame_clk;
            m_lap  = 0;
            case (m_state)
                0: begin
                    m_arm();
                    if (start) m_state = 1;
                end
                1: begin
                    if (hit) m_state = 3;
                    else begin
                        m_coin = m_coin & ~int'(coin_hit) & 7;
                        if (tick_now) begin
                            sum = m_fc + m_step;
                            m_runticks++;
                            if (sum >= FM) begin m_lap = 1; m_coin = 7; end
                            m_fc   = sum % FM;
                            m_step = SMIN + m_runticks / RAMP;
                            if (m_step > SMAX) m_step = SMAX;
                        end
                        if (pause) m_state = 2;
                    end
                end
                2: if (!pause) m_state = 1;
                default: if (start) begin m_state = 0; m_arm(); end
            endcase
        end
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            chk("state",         state,         m_state);
            chk("playing",       playing,       (m_state == 1) ? 1 : 0);
            chk("frame_counter", frame_counter, m_fc);
            chk("step",          step,          m_step);
            chk("CoinStatus",    CoinStatus,    m_coin);
            chk("lap_done",      lap_done,      m_lap);
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers: each tick takes two cycles; c/h/s are applied in
    // the cycle in which the registered tick is high.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge Clk); #1;
    endtask

    task automatic do_tick(input logic [2:0] c, input logic h, input logic s);
        frame_clk = 1'b1;
        cyc();
        frame_clk = 1'b0;
        coin_hit  = c;
        hit       = h;
        start     = s;
        cyc();
        coin_hit  = 3'b000;
        hit       = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        #(20 * 60000);
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        Reset_n = 1'b0; frame_clk = 1'b0; start = 1'b0; pause = 1'b0;
        hit = 1'b0; coin_hit = 3'b000;
        cyc(); cyc();
        chk("rst_state", state, 0);
        chk("rst_fc",    frame_counter, 0);
        chk("rst_step",  step, 2);
        chk("rst_coin",  CoinStatus, 7);
        chk("rst_lap",   lap_done, 0);
        chk("rst_play",  playing, 0);
        Reset_n = 1'b1;

        start = 1'b1; cyc(); start = 1'b0;
        chk("start_run", state, 1);
        ticks(3);
        chk("t3_fc",   frame_counter, 6);
        chk("t3_step", step, 2);
        chk("t3_coin", CoinStatus, 7);
        chk("t3_play", playing, 1);

        coin_hit = 3'b010; cyc(); coin_hit = 3'b000;
        chk("coin_clr", CoinStatus, 3'b101);

        ticks(596);
        chk("t599_fc",   frame_counter, 1198);
        chk("t599_step", step, 2);
        ticks(1);
        chk("t600_fc",   frame_counter, 1200);
        chk("t600_step", step, 3);
        ticks(623);
        chk("t1223_fc",   frame_counter, 3092);
        chk("t1223_step", step, 4);
        do_tick(3'b001, 1'b0, 1'b0);
        chk("wrap_fc",   frame_counter, 0);
        chk("wrap_lap",  lap_done, 1);
        chk("wrap_coin", CoinStatus, 7);
        cyc();
        chk("lap_pulse_end", lap_done, 0);

        ticks(1);
        chk("pre_pause_fc", frame_counter, 4);
        pause = 1'b1; cyc();
        chk("pause_state", state, 2);
        chk("pause_play",  playing, 0);
        ticks(10);
        chk("pause_fc",   frame_counter, 4);
        chk("pause_step", step, 4);
        pause = 1'b0; cyc();
        chk("resume_state", state, 1);
        ticks(1);
        chk("resume_fc", frame_counter, 8);

        ticks(3000 - 1227);
        chk("sat_step", step, 6);

        Reset_n = 1'b0; cyc(); Reset_n = 1'b1;
        chk("midrun_rst_state", state, 0);
        chk("midrun_rst_fc",    frame_counter, 0);
        chk("midrun_rst_step",  step, 2);

        start = 1'b1; cyc(); start = 1'b0;
        ticks(50);
        chk("pre_hit_fc", frame_counter, 100);
        do_tick(3'b100, 1'b1, 1'b1);
        chk("hit_state", state, 3);
        chk("hit_fc",    frame_counter, 100);
        chk("hit_coin",  CoinStatus, 7);
        cyc();
        chk("over_idle_state", state, 0);
        chk("over_idle_fc",    frame_counter, 0);
        cyc();
        chk("idle_run_state", state, 1);
        start = 1'b0;

        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(3) == 0) frame_clk = ~frame_clk;
            start    = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) pause = ~pause;
            hit      = ($urandom_range(199) == 0);
            coin_hit = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'b000;
            Reset_n  = ($urandom_range(499) != 0);
            cyc();
        end

        Reset_n = 1'b1; start = 1'b0; pause = 1'b0; hit = 1'b0; coin_hit = 3'b000;
        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_scroll_ctrl
`default_nettype wire
